// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings and buffer depth.
package imm_ext_pkg;

  localparam int MODE_W     = 2;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extension: turns a raw field plus mode into a full-width value.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  ext_value
);

  // The upper mode needs room for the field shifted up by its own width,
  // and a sign bit only makes sense with at least two bits of field.
  if (OUT_W < 2*IN_W || IN_W < 2) begin : g_bad_width
    $error("imm_ext_core: OUT_W must be >= 2*IN_W and IN_W must be >= 2");
  end

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  // Select the extension rule; branch offsets are word-aligned, so the sign-extended value moves up two bits.
  always_comb begin
    ext_value = '0;
    case (imm_mode_e'(in_mode))
      MODE_SIGN:   ext_value = sext;
      MODE_ZERO:   ext_value[IN_W-1:0] = in_imm;
      MODE_UPPER:  ext_value[IN_W +: IN_W] = in_imm;
      MODE_BRANCH: ext_value = sext << 2;
      default:     ext_value = '0;
    endcase
  end

endmodule

// File: rtl/imm_extender.sv
// Immediate extender with a two-entry output FIFO; results are registered, never bypassed.
module imm_extender
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [MODE_W-1:0] out_mode
);

  // Pointers are single bits and the count is two bits, so only a depth of two fits this control.
  if (DEPTH != FIFO_DEPTH) begin : g_bad_depth
    $error("imm_extender: DEPTH must be 2");
  end

  logic [OUT_W-1:0]  ext_value;
  logic [OUT_W-1:0]  data_q [FIFO_DEPTH];
  logic [OUT_W-1:0]  data_d [FIFO_DEPTH];
  logic [MODE_W-1:0] mode_q [FIFO_DEPTH];
  logic [MODE_W-1:0] mode_d [FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .ext_value (ext_value)
  );

  // Handshake flags come from the registered count only, so out_ready never reaches in_ready.
  always_comb begin
    out_valid = (count_q != 2'd0);
    in_ready  = (count_q != 2'(FIFO_DEPTH));
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = data_q[rd_ptr_q];
    out_mode  = mode_q[rd_ptr_q];
  end

  // Next-state of the buffer: write at the tail on accept, advance the head on pop.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = ext_value;
      mode_d[wr_ptr_q] = in_mode;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Register the buffer; reset clears every entry so the output reads zero and stale data is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q   <= '{default: '0};
      mode_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// Bench for imm_extender: directed scenarios plus random traffic against a queue-based reference.
module tb_imm_extender;
  import imm_ext_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  int assert_count = 0;
  int fail_count   = 0;

  logic [33:0] model_q [$];

  imm_extender #(
    .IN_W  (16),
    .OUT_W (32),
    .DEPTH (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  // Free-running clock, 10 time units per cycle.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Guard against the run stalling forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference extension computed from the arithmetic meaning of each mode.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    longint r;
    logic [63:0] rv;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * 65536;
      default: r = s * 4;
    endcase
    rv = 64'(r);
    return rv[31:0];
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic rdy);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, updating the reference queue with the handshakes of this cycle.
  task automatic stepCycle();
    logic        do_push;
    logic        do_pop;
    logic [33:0] entry;
    do_push = in_valid && (model_q.size() != 2);
    do_pop  = out_ready && (model_q.size() != 0);
    if (Reset) begin
      model_q.delete();
    end else begin
      if (do_pop) entry = model_q.pop_front();
      if (do_push) model_q.push_back({in_mode, ref_ext(in_imm, in_mode)});
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic [33:0] head;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'(model_q.size() != 2));
    if (model_q.size() != 0) begin
      head = model_q[0];
      checkOutput({tag, "_data"}, out_data, head[31:0]);
      checkOutput({tag, "_mode"}, 32'(out_mode), 32'(head[33:32]));
    end
  endtask

  task automatic runOne(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [31:0] exp);
    applyStimulus(1'b1, imm, mode, 1'b1);
    #1;
    checkOutput({tag, "_nobypass"}, 32'(out_valid), 32'd0);
    stepCycle();
    checkOutput(tag, out_data, exp);
    checkOutput({tag, "_omode"}, 32'(out_mode), 32'(mode));
    checkModel(tag);
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b1);
    stepCycle();
    checkModel({tag, "_drain"});
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b0);
    stepCycle();
    stepCycle();
    Reset = 1'b0;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_data", out_data, 32'h0);
    checkOutput("rst_mode", 32'(out_mode), 32'd0);

    // Back-to-back sign extensions, each visible one cycle after acceptance.
    applyStimulus(1'b1, 16'hFFFF, MODE_SIGN, 1'b1);
    #1;
    checkOutput("sign1_nobypass", 32'(out_valid), 32'd0);
    stepCycle();
    checkOutput("sign1", out_data, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 16'hAAAA, MODE_SIGN, 1'b1);
    stepCycle();
    checkOutput("sign2", out_data, 32'hFFFF_AAAA);
    checkModel("sign2");
    applyStimulus(1'b0, 16'h0, MODE_SIGN, 1'b1);
    stepCycle();
    checkModel("sign_drain");

    runOne("zero",    16'hAAAA, MODE_ZERO,   32'h0000_AAAA);
    runOne("upper",   16'h1234, MODE_UPPER,  32'h1234_0000);
    runOne("branchn", 16'hFFFE, MODE_BRANCH, 32'hFFFF_FFF8);
    runOne("branchp", 16'h7FFF, MODE_BRANCH, 32'h0001_FFFC);

    // Stall: two entries fill the buffer, the third waits until space opens.
    applyStimulus(1'b1, 16'h0001, MODE_ZERO, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0002, MODE_ZERO, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0003, MODE_ZERO, 1'b0);
    checkOutput("stall_full_ready", 32'(in_ready), 32'd0);
    checkOutput("stall_head", out_data, 32'h1);
    stepCycle();
    checkOutput("stall_hold_data", out_data, 32'h1);
    checkOutput("stall_hold_ready", 32'(in_ready), 32'd0);
    checkModel("stall_hold");
    applyStimulus(1'b1, 16'h0003, MODE_ZERO, 1'b1);
    stepCycle();
    checkOutput("stall_out2", out_data, 32'h2);
    checkOutput("stall_ready_rise", 32'(in_ready), 32'd1);
    stepCycle();
    checkOutput("stall_out3", out_data, 32'h3);
    checkModel("stall_out3");
    applyStimulus(1'b0, 16'h0, MODE_ZERO, 1'b1);
    stepCycle();
    checkOutput("stall_empty", 32'(out_valid), 32'd0);

    // Steady state at one entry with push and pop on every edge.
    applyStimulus(1'b1, 16'($urandom), MODE_SIGN, 1'b0);
    stepCycle();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'($urandom), MODE_SIGN, 1'b1);
      stepCycle();
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkModel("stream");
    end
    applyStimulus(1'b0, 16'h0, MODE_SIGN, 1'b1);
    stepCycle();
    stepCycle();
    checkModel("stream_drain");

    // Reset while full, with handshakes asserted that must be ignored.
    applyStimulus(1'b1, 16'h1111, MODE_ZERO, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h2222, MODE_ZERO, 1'b0);
    stepCycle();
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    Reset = 1'b1;
    applyStimulus(1'b1, 16'h3333, MODE_SIGN, 1'b1);
    stepCycle();
    Reset = 1'b0;
    applyStimulus(1'b0, 16'h0, MODE_SIGN, 1'b1);
    checkOutput("mrst_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_data", out_data, 32'h0);
    checkOutput("mrst_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h8000, MODE_SIGN, 1'b1);
    stepCycle();
    checkOutput("mrst_next", out_data, 32'hFFFF_8000);
    checkModel("mrst_next");
    applyStimulus(1'b0, 16'h0, MODE_SIGN, 1'b1);
    stepCycle();

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      stepCycle();
      checkModel("rand");
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
